// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle main control FSM for a LEGv8 datapath: sequences fetch, decode,
// execute, memory and write-back, stalls on mem_ready and traps on bad opcodes.
module legv8_multicycle_ctrl #(
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] inst31_21,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        pc_src,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        reg2loc,
    output logic [1:0]  ALUOp,
    output logic        illegal,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        R_EX   = 4'd2,
        I_EX   = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_ALU = 4'd7,
        WB_LD  = 4'd8,
        B_EX   = 4'd9,
        CBZ_EX = 4'd10,
        TRAP   = 4'd11
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    state_t      state_q, state_d;
    logic [10:0] opcode_q, opcode_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        illegal_q, illegal_d;

    logic [7:0]  wait_inc;
    logic        wait_expired;
    logic        is_stur;
    logic        is_cbz;

    function automatic state_t dispatch(input logic [10:0] op);
        state_t nxt;
        nxt = TRAP;
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR)
            nxt = R_EX;
        else if (op[10:1] == 10'b1001000100)
            nxt = I_EX;
        else if (op == OP_LDUR || op == OP_STUR)
            nxt = ADDR;
        else if (op[10:5] == 6'b000101)
            nxt = B_EX;
        else if (op[10:3] == 8'b10110100)
            nxt = CBZ_EX;
        return nxt;
    endfunction

    assign is_stur      = (opcode_q == OP_STUR);
    assign is_cbz       = (opcode_q[10:3] == 8'b10110100);
    assign wait_inc     = wait_cnt_q + 8'd1;
    assign wait_expired = (WAIT_MAX != 0) && (wait_inc == 8'(WAIT_MAX));
    assign state_dbg    = state_q;

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        wait_cnt_d = 8'd0;
        illegal_d  = illegal_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg2loc    = 1'b0;
        ALUOp      = 2'b00;
        illegal    = illegal_q;

        case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    opcode_d = inst31_21;
                    state_d  = DECODE;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_expired) state_d = TRAP;
                end
            end
            DECODE: begin
                reg2loc = is_stur | is_cbz;
                state_d = dispatch(opcode_q);
            end
            R_EX: begin
                ALUOp   = 2'b10;
                state_d = WB_ALU;
            end
            I_EX: begin
                alu_src = 1'b1;
                state_d = WB_ALU;
            end
            WB_ALU: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            ADDR: begin
                alu_src = 1'b1;
                reg2loc = is_stur;
                state_d = is_stur ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = WB_LD;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_expired) state_d = TRAP;
                end
            end
            WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                reg2loc   = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_expired) state_d = TRAP;
                end
            end
            B_EX: begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
                state_d  = FETCH;
            end
            CBZ_EX: begin
                ALUOp    = 2'b01;
                reg2loc  = 1'b1;
                pc_src   = 1'b1;
                pc_write = zero;
                state_d  = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
            end
        endcase

        if (state_d == TRAP) illegal_d = 1'b1;

        // While reset is held the datapath sees a quiet FETCH with no handshake.
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b1;
            mem_write  = 1'b0;
            iord       = 1'b0;
            pc_src     = 1'b0;
            alu_src    = 1'b0;
            mem_to_reg = 1'b0;
            reg2loc    = 1'b0;
            ALUOp      = 2'b00;
            illegal    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            opcode_q   <= 11'd0;
            wait_cnt_q <= 8'd0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
        end
    end

endmodule

// File: doc/legv8_multicycle_ctrl.md
# legv8_multicycle_ctrl

Multi-cycle main control FSM for the LEGv8 CPU. Latches the instruction opcode field (inst31_21) and sequences fetch, decode, execute, memory and write-back over several clock cycles. It drives the shared datapath enables and the 2-bit ALUOp consumed by the ALU control decoder. It stalls on a single-ported memory ready handshake and traps on unsupported opcodes.

## Interface
- WAIT_MAX, 255: memory-wait cycles tolerated before the timeout trap; 0 disables the timeout.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inst31_21  in  11  opcode field from memory read data; sampled only while ir_write=1.
- zero  in  1  ALU zero flag; valid in CBZ_EX.
- mem_ready  in  1  memory completes the current mem_read/mem_write access this cycle.
- pc_write, ir_write, reg_write, mem_read, mem_write  out  1 each  datapath enables.
- iord  out  1  memory address source: 0=PC, 1=ALU out register.
- pc_src  out  1  PC source: 0=PC+4, 1=branch target.
- alu_src  out  1  ALU B operand: 0=register, 1=sign-extended immediate.
- mem_to_reg  out  1  write-back source: 0=ALU out, 1=memory data register.
- reg2loc  out  1  register read port 2 select: 0=Rm, 1=Rt.
- ALUOp  out  2  00=add (address/ADDI path), 01=pass B (CBZ), 10=R-type decode.
- illegal  out  1  sticky trap flag.
- state_dbg  out  4  current state encoding.

## Operation
- States: FETCH, DECODE, R_EX, I_EX, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_LD, B_EX, CBZ_EX, TRAP.
- All outputs default to 0. The state register resets to FETCH.
- FETCH: mem_read=1, iord=0. While mem_ready=0, stay in FETCH. When mem_ready=1 in the same cycle: ir_write=1, pc_write=1, pc_src=0, latch inst31_21 into the opcode register, then go to DECODE.
- DECODE: reg2loc=1 if the latched opcode is STUR or CBZ. Dispatch on the latched opcode:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> R_EX.
  - ADDI 1001000100x -> I_EX.
  - LDUR 11111000010, STUR 11111000000 -> ADDR.
  - B 000101xxxxx -> B_EX.
  - CBZ 10110100xxx -> CBZ_EX.
  - Anything else -> TRAP.
- R_EX: ALUOp=10, alu_src=0 -> WB_ALU.
- I_EX: ALUOp=00, alu_src=1 -> WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0 -> FETCH.
- ADDR: ALUOp=00, alu_src=1, reg2loc held from DECODE. Go to MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: mem_read=1, iord=1. On mem_ready go to WB_LD, otherwise hold.
- WB_LD: reg_write=1, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_write=1, iord=1, reg2loc=1. On mem_ready go to FETCH, otherwise hold.
- B_EX: pc_write=1, pc_src=1 -> FETCH.
- CBZ_EX: ALUOp=01, reg2loc=1, pc_src=1, pc_write=zero -> FETCH.
- TRAP: all enables 0, illegal=1. Stays in TRAP until reset.
- Wait counter: 8-bit, cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle mem_ready=0 in those states. If the counter reaches WAIT_MAX and WAIT_MAX!=0, go to TRAP on the next edge.

## Timing
- Outputs are decoded from the state register and the latched opcode; the FETCH/MEM handshake terms are combinational on mem_ready.
- Latency with zero-wait memory, FETCH entry to next FETCH entry:
  - R-type and ADDI: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - B and CBZ: 3 cycles.
- Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly 1 cycle.
- Reset asserted in any state, including mid-memory-wait or TRAP: on the next edge state=FETCH, illegal=0, opcode register=0, wait counter=0.
- While reset is high the outputs reflect FETCH: mem_read=1 and nothing else. ir_write and pc_write are forced to 0 while reset=1, even if mem_ready=1.
- mem_read and mem_write are never both 1 in the same cycle.
- pc_write is 1 in at most one cycle per non-branch instruction, and at most two cycles for B/CBZ (fetch plus branch).

## Test plan
- ADD 10001011000, mem_ready tied 1 -> states FETCH, DECODE, R_EX, WB_ALU; ALUOp=10 in R_EX; reg_write=1 in cycle 4 only.
- LDUR 11111000010 with mem_ready low 2 cycles in MEM_RD -> MEM_RD lasts 3 cycles; WB_LD has mem_to_reg=1 and reg_write=1; total 7 cycles.
- CBZ 10110100101: zero=1 gives pc_write=1, pc_src=1 in CBZ_EX; zero=0 gives pc_write=0; ALUOp=01 in both cases.
- STUR 11111000000 -> reg2loc=1 in DECODE, ADDR and MEM_WR; mem_write=1, iord=1 until mem_ready; reg_write is never 1.
- Opcode 11111111111 -> TRAP after DECODE; illegal=1 held 20 cycles with every enable 0; reset for 1 cycle -> FETCH, illegal=0.
- WAIT_MAX=4 with mem_ready stuck 0 in FETCH -> TRAP entered after exactly 4 wait cycles. Separately, reset asserted mid-MEM_RD -> FETCH on the next edge with wait counter 0.
